// File: rtl/pfd_loop_filter.sv
// PI loop filter behind the PFD pulse synchronizer: counts UP/DOWN pulses over a
// fixed window, filters the signed error and drives the DCO control word.
module pfd_loop_filter #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned WINDOW    = 256,
  parameter int unsigned INT_W     = 24,
  parameter int unsigned CTRL_W    = 16,
  parameter int unsigned KP_SHIFT  = 4,
  parameter int unsigned KI_SHIFT  = 0,
  parameter logic [CTRL_W-1:0] CTRL_INIT = CTRL_W'('h8000),
  parameter int unsigned LOCK_TOL  = 1,
  parameter int unsigned LOCK_CNT  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_pulse,
  input  logic                    down_pulse,
  output logic signed [CNT_W:0]   phase_err,
  output logic [CTRL_W-1:0]       ctrl_word,
  output logic                    ctrl_valid,
  output logic                    locked
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned LK_W  = $clog2(LOCK_CNT + 1);
  localparam logic signed [CNT_W:0] TOL = (CNT_W+1)'(LOCK_TOL);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [WIN_W-1:0]        win_cnt;
  logic [CNT_W-1:0]        up_cnt, dn_cnt;
  logic [CNT_W-1:0]        snap_up, snap_dn;
  logic                    win_last;
  logic                    err_vld, stg2_vld;
  logic signed [INT_W-1:0] integ, p_term;
  logic [LK_W-1:0]         lock_cnt;

  logic signed [INT_W:0]   err_ki, integ_sum;
  logic signed [INT_W-1:0] integ_sat, p_next;
  logic signed [INT_W+1:0] total;
  logic [CTRL_W-1:0]       ctrl_next;
  logic                    in_tol;

  // Saturating count including this cycle's pulse; doubles as the window snapshot.
  always_comb begin
    snap_up  = (up_pulse   && (up_cnt != '1)) ? up_cnt + CNT_W'(1) : up_cnt;
    snap_dn  = (down_pulse && (dn_cnt != '1)) ? dn_cnt + CNT_W'(1) : dn_cnt;
    win_last = (win_cnt == WIN_W'(WINDOW - 1));
  end

  // Run/idle control, window timing, pulse counting and the error stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      win_cnt   <= '0;
      up_cnt    <= '0;
      dn_cnt    <= '0;
      phase_err <= '0;
      err_vld   <= 1'b0;
    end else begin
      err_vld <= 1'b0;
      case (state)
        IDLE: begin
          win_cnt <= '0;
          up_cnt  <= '0;
          dn_cnt  <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state   <= IDLE;
            win_cnt <= '0;
            up_cnt  <= '0;
            dn_cnt  <= '0;
          end else if (win_last) begin
            win_cnt   <= '0;
            up_cnt    <= '0;
            dn_cnt    <= '0;
            phase_err <= $signed({1'b0, snap_up}) - $signed({1'b0, snap_dn});
            err_vld   <= 1'b1;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            up_cnt  <= snap_up;
            dn_cnt  <= snap_dn;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Integrator saturation, proportional term, output clamp and lock tolerance.
  always_comb begin
    err_ki    = (INT_W+1)'(phase_err) <<< KI_SHIFT;
    integ_sum = (INT_W+1)'(integ) + err_ki;
    if (integ_sum[INT_W] != integ_sum[INT_W-1])
      integ_sat = integ_sum[INT_W] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    else
      integ_sat = integ_sum[INT_W-1:0];
    p_next = INT_W'(phase_err) <<< KP_SHIFT;
    total  = {{(INT_W+2-CTRL_W){1'b0}}, CTRL_INIT} + (INT_W+2)'(integ) + (INT_W+2)'(p_term);
    if (total[INT_W+1])
      ctrl_next = '0;
    else if (|total[INT_W:CTRL_W])
      ctrl_next = '1;
    else
      ctrl_next = total[CTRL_W-1:0];
    in_tol = (phase_err <= TOL) && (phase_err >= -TOL);
  end

  // Filter pipeline: integrate/scale one cycle after the error, then update the
  // control word and lock flag together; dropping en clears lock tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      integ      <= '0;
      p_term     <= '0;
      stg2_vld   <= 1'b0;
      lock_cnt   <= '0;
      ctrl_word  <= CTRL_INIT;
      ctrl_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      stg2_vld   <= err_vld;
      ctrl_valid <= 1'b0;
      if (err_vld) begin
        integ  <= integ_sat;
        p_term <= p_next;
        if (!in_tol)
          lock_cnt <= '0;
        else if (lock_cnt != LK_W'(LOCK_CNT))
          lock_cnt <= lock_cnt + LK_W'(1);
      end
      if (stg2_vld) begin
        ctrl_word  <= ctrl_next;
        ctrl_valid <= 1'b1;
        locked     <= (lock_cnt == LK_W'(LOCK_CNT));
      end
      if (!en) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Directed bench for pfd_loop_filter: three instances share stimulus and differ only in
// CTRL_INIT so both clamp limits can be exercised.
module tb_pfd_loop_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, up_pulse, down_pulse;
  logic signed [8:0] pe0, pe1, pe2;
  logic [15:0] cw0, cw1, cw2;
  logic cv0, cv1, cv2, lk0, lk1, lk2;

  pfd_loop_filter #(.CNT_W(8), .WINDOW(16), .INT_W(24), .CTRL_W(16), .KP_SHIFT(2),
    .KI_SHIFT(0), .CTRL_INIT(16'h8000), .LOCK_TOL(1), .LOCK_CNT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up_pulse(up_pulse), .down_pulse(down_pulse),
    .phase_err(pe0), .ctrl_word(cw0), .ctrl_valid(cv0), .locked(lk0));

  pfd_loop_filter #(.CNT_W(8), .WINDOW(16), .INT_W(24), .CTRL_W(16), .KP_SHIFT(2),
    .KI_SHIFT(0), .CTRL_INIT(16'hFFF0), .LOCK_TOL(1), .LOCK_CNT(4)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .up_pulse(up_pulse), .down_pulse(down_pulse),
    .phase_err(pe1), .ctrl_word(cw1), .ctrl_valid(cv1), .locked(lk1));

  pfd_loop_filter #(.CNT_W(8), .WINDOW(16), .INT_W(24), .CTRL_W(16), .KP_SHIFT(2),
    .KI_SHIFT(0), .CTRL_INIT(16'h0010), .LOCK_TOL(1), .LOCK_CNT(4)) dut_lo (
    .clk(clk), .rst(rst), .en(en), .up_pulse(up_pulse), .down_pulse(down_pulse),
    .phase_err(pe2), .ctrl_word(cw2), .ctrl_valid(cv2), .locked(lk2));

  int checks = 0;
  int failures = 0;

  // Expectations for the most recent window, checked over the following cycles.
  bit pend = 1'b0;
  int since, p_sel, p_ctrl, p_lock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int sel_cw(input int s);
    return (s == 1) ? int'(cw1) : (s == 2) ? int'(cw2) : int'(cw0);
  endfunction
  function automatic int sel_cv(input int s);
    return (s == 1) ? int'(cv1) : (s == 2) ? int'(cv2) : int'(cv0);
  endfunction
  function automatic int sel_lk(input int s);
    return (s == 1) ? int'(lk1) : (s == 2) ? int'(lk2) : int'(lk0);
  endfunction
  function automatic int sel_pe(input int s);
    return (s == 1) ? int'(pe1) : (s == 2) ? int'(pe2) : int'(pe0);
  endfunction

  task automatic check_reset_vals();
    check("rst_ctrl_word", int'(cw0), 'h8000);
    check("rst_phase_err", int'(pe0), 0);
    check("rst_ctrl_valid", int'(cv0), 0);
    check("rst_locked", int'(lk0), 0);
  endtask

  // One clock of stimulus; samples 1 time unit after the edge.
  task automatic step(input logic u, input logic d);
    up_pulse   = u;
    down_pulse = d;
    @(posedge clk);
    #1;
    if (pend) begin
      since++;
      case (since)
        2: check("valid_T2", sel_cv(p_sel), 0);
        3: begin
          check("valid_T3", sel_cv(p_sel), 1);
          check("ctrl_word", sel_cw(p_sel), p_ctrl);
          check("locked", sel_lk(p_sel), p_lock);
        end
        default: begin
          check("valid_T4", sel_cv(p_sel), 0);
          pend = 1'b0;
        end
      endcase
    end
  endtask

  // One full window of pulses (bit i = window cycle i), then schedule its checks.
  task automatic win(input logic [15:0] um, input logic [15:0] dm, input int sel,
                     input int e, input int c, input int l);
    for (int i = 0; i < 16; i++) step(um[i], dm[i]);
    check("phase_err", sel_pe(sel), e);
    pend   = 1'b1;
    since  = 1;
    p_sel  = sel;
    p_ctrl = c;
    p_lock = l;
  endtask

  task automatic flush();
    repeat (3) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; up_pulse = 1'b0; down_pulse = 1'b0; pend = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b1;
  endtask

  // Raise en; the first clock moves IDLE->RUN, the next one is window cycle 0.
  task automatic start();
    en = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset and idle with pulses present
    rst = 1'b0; en = 1'b0; up_pulse = 1'b0; down_pulse = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(logic'(i[0]), 1'b0);
      check("idle_ctrl_word", int'(cw0), 'h8000);
      check("idle_phase_err", int'(pe0), 0);
      check("idle_ctrl_valid", int'(cv0), 0);
      check("idle_locked", int'(lk0), 0);
    end

    // Positive error: 5 ups then an empty window
    start();
    win(16'h001F, 16'h0000, 0, 5, 'h8019, 0);
    win(16'h0000, 16'h0000, 0, 0, 'h8005, 0);
    flush();

    // Simultaneous up/down plus two lone downs
    do_reset();
    start();
    win(16'h0070, 16'h0370, 0, -2, 'h7FF6, 0);
    flush();

    // Window boundary pulses, then en drop mid-window
    do_reset();
    start();
    win(16'h8000, 16'h0000, 0, 1, 'h8005, 0);
    win(16'h0001, 16'h0000, 0, 1, 'h8006, 0);
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    en = 1'b0;
    step(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0);
      check("abort_ctrl_valid", int'(cv0), 0);
      check("abort_ctrl_word", int'(cw0), 'h8006);
    end
    start();
    win(16'h0000, 16'h0000, 0, 0, 'h8002, 0);
    flush();

    // Clamp at the top and bottom of the control range
    do_reset();
    start();
    win(16'hFFFF, 16'h0000, 1, 16, 'hFFFF, 0);
    win(16'hFFFF, 16'h0000, 1, 16, 'hFFFF, 0);
    flush();
    do_reset();
    start();
    win(16'h0000, 16'hFFFF, 2, -16, 'h0000, 0);
    win(16'h0000, 16'hFFFF, 2, -16, 'h0000, 0);
    flush();

    // Lock acquisition, loss, then asynchronous reset mid-window
    do_reset();
    start();
    win(16'h0001, 16'h0000, 0, 1, 'h8005, 0);
    win(16'h0000, 16'h0001, 0, -1, 'h7FFC, 0);
    win(16'h0000, 16'h0000, 0, 0, 'h8000, 0);
    win(16'h0001, 16'h0000, 0, 1, 'h8005, 1);
    win(16'h0007, 16'h0000, 0, 3, 'h8010, 0);
    flush();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pfd_loop_filter.md
Name: pfd_loop_filter

Overview:
- Digital PI loop filter stage directly downstream of the PFD pulse-synchronizer interface.
- Consumes the single-cycle, clk-domain UP/DOWN pulses and counts them over a fixed measurement window to form a signed phase error.
- Runs a saturating proportional-integral filter on that error and drives the DCO control word.
- Provides a lock indicator for the top level.

Parameters:
- CNT_W, 8: width of the per-window UP/DOWN counters (saturating).
- WINDOW, 256: measurement window length in clk cycles (≥ 4).
- INT_W, 24: signed integrator width (≥ CTRL_W+1).
- CTRL_W, 16: control word width (unsigned).
- KP_SHIFT, 4: proportional gain = 2^KP_SHIFT.
- KI_SHIFT, 0: integral gain = 2^KI_SHIFT.
- CTRL_INIT, 16'h8000: control word centre and reset value.
- LOCK_TOL, 1: maximum |error| for a window to count as in-lock.
- LOCK_CNT, 8: consecutive in-lock windows required to assert locked.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  loop enable.
- up_pulse  in  1  synchronized UP pulse, 1 cycle wide.
- down_pulse  in  1  synchronized DOWN pulse, 1 cycle wide.
- phase_err  out  CNT_W+1  signed per-window error (up - down).
- ctrl_word  out  CTRL_W  DCO control word.
- ctrl_valid  out  1  1-cycle strobe; ctrl_word updated this cycle.
- locked  out  1  lock indicator.

Behaviour:
- Reset, clk, and enable:
  - Reset (rst=0, asynchronous) sets ctrl_word=CTRL_INIT, phase_err=0, ctrl_valid=0, locked=0; clears integrator, window counter, up/down counters, lock counter and pipeline valids.
  - Reset applied mid-window or mid-pipeline discards all in-flight data.
  - All other logic is synchronous to clk.
- FSM, two states:
  - IDLE: entered from reset, and whenever en=0. Counters and window counter are held at 0; ctrl_word and integrator hold; pulses are ignored.
  - RUN: entered on en=1. Window counter runs 0..WINDOW-1 and wraps.
  - en falling mid-window: the partial window is discarded and the state goes to IDLE next cycle. Pipeline stages already launched complete normally.
- Counting:
  - up_cnt and dn_cnt increment on their pulse and saturate at 2^CNT_W-1 (no wrap).
  - Simultaneous up and down in one cycle increments both.
- Window end (win_cnt==WINDOW-1):
  - Snapshot values = counter + that cycle's pulse, saturated.
  - Counters restart from 0 next cycle; no pulse is lost or double-counted.
- Pipeline, relative to window-end cycle T:
  - T+1: phase_err <= snap_up - snap_dn (signed, CNT_W+1 bits).
  - T+2: integ <= sat_INT_W(integ + (phase_err << KI_SHIFT)); p_term <= phase_err << KP_SHIFT.
  - T+3: ctrl_word <= clamp(CTRL_INIT + integ + p_term, 0, 2^CTRL_W-1); ctrl_valid=1 for exactly this cycle.
  - The T+3 sum is computed at INT_W+2 bits, so there is no intermediate overflow.
  - Sign convention: positive error raises ctrl_word.
- Lock:
  - Evaluated at T+1 on phase_err.
  - |phase_err| ≤ LOCK_TOL increments lock_cnt (saturating at LOCK_CNT); otherwise lock_cnt clears.
  - locked is updated at T+3 together with ctrl_word: locked=1 iff lock_cnt==LOCK_CNT.
  - Any out-of-tolerance window drops locked at that window's T+3.
  - Entering IDLE clears lock_cnt and locked.
- Between strobes, ctrl_word is held constant.

Test Plan:
Common overrides: WINDOW=16, KP_SHIFT=2, KI_SHIFT=0, CTRL_W=16, INT_W=24, CTRL_INIT=0x8000, LOCK_TOL=1, LOCK_CNT=4.
1. Reset and idle:
   - Stimulus: rst low 5 cycles; release with en=0 for 40 cycles; toggle up_pulse during idle.
   - Required: ctrl_word=0x8000, phase_err=0, ctrl_valid=0, locked=0 throughout.
2. Positive error:
   - Stimulus: en=1; 5 up pulses in window 1, none in window 2.
   - Required: window 1 gives phase_err=+5, ctrl_word=0x8019 with ctrl_valid exactly at window-end+3; window 2 gives phase_err=0, ctrl_word=0x8005.
3. Simultaneous and negative:
   - Stimulus: up and down high together on 3 cycles, plus 2 lone down pulses.
   - Required: phase_err=-2, ctrl_word=0x7FF6.
4. Window boundary:
   - Stimulus: up pulse on cycle WINDOW-1, then another on the first cycle of the next window.
   - Required: each window reports phase_err=+1. Then drop en mid-window after 3 up pulses: no ctrl_valid for that window, ctrl_word unchanged.
5. Saturation:
   - Stimulus: CTRL_INIT=0xFFF0, up_pulse high every cycle.
   - Required: phase_err=+16, ctrl_word clamps to 0xFFFF (no wrap), holding 0xFFFF on later strobes. Mirror with down pulses from CTRL_INIT=0x0010: clamps to 0x0000.
6. Lock:
   - Stimulus: 4 consecutive windows with |err| ≤ 1, then one window with err=+3, then rst asserted mid-window.
   - Required: locked rises with the 4th ctrl_valid; falls at the err=+3 window's ctrl_valid; after rst, all outputs return to reset values immediately.
